// File: rtl/veldt_mem_pkg.sv
// Shared definitions for the Veldt RAM arbiter: ram_in field layout, owner tags
// and the request packer used by the arbiter datapath.
package veldt_mem_pkg;

    localparam int RAM_IN_W  = 97;
    localparam int ADDR_LSB  = 65;
    localparam int WDATA_LSB = 33;
    localparam int MASK_LSB  = 29;
    localparam int WE_BIT    = 28;
    localparam int REQ_BIT   = 27;

    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
        logic   we;
    } tag_t;

    // Unused low bits of the request word stay zero.
    function automatic logic [RAM_IN_W-1:0] pack_req(input logic [31:0] addr,
                                                     input logic [31:0] wdata,
                                                     input logic [3:0]  mask,
                                                     input logic        we);
        logic [RAM_IN_W-1:0] r;
        r                   = '0;
        r[ADDR_LSB +: 32]   = addr;
        r[WDATA_LSB +: 32]  = wdata;
        r[MASK_LSB +: 4]    = mask;
        r[WE_BIT]           = we;
        r[REQ_BIT]          = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/veldt_mem_arbiter_if.sv
// Requester and RAM-side signal bundle of the Veldt RAM arbiter.
// master = core front-end/LSU plus RAM model; slave = the arbiter.
interface veldt_mem_arbiter_if #(parameter int ADDR_W = 32);

    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [31:0]       i_rsp_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_we;
    logic [31:0]       d_req_wdata;
    logic [3:0]        d_req_mask;
    logic              d_rsp_valid;
    logic [31:0]       d_rsp_rdata;

    logic [96:0]       ram_in;
    logic [31:0]       ram_out;

    modport master (
        output i_req_valid, i_req_addr,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_mask,
        output ram_out,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata,
        input  ram_in
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_mask,
        input  ram_out,
        output i_req_ready, i_rsp_valid, i_rsp_rdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata,
        output ram_in
    );

endinterface

// File: rtl/veldt_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; grants are combinational
// and forced low while reset is asserted.
module veldt_rr_arb2
    import veldt_mem_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    owner_e last_q, last_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) last_q <= OWN_I;
        else       last_q <= last_d;
    end

    always_comb begin
        gnt_i  = 1'b0;
        gnt_d  = 1'b0;
        last_d = last_q;
        if (!reset) begin
            if (req_i && req_d) begin
                if (last_q == OWN_I) gnt_d = 1'b1;
                else                 gnt_i = 1'b1;
            end else begin
                gnt_i = req_i;
                gnt_d = req_d;
            end
            // Pointer only moves when something was actually granted.
            if (gnt_i)      last_d = OWN_I;
            else if (gnt_d) last_d = OWN_D;
        end
    end

endmodule

// File: rtl/veldt_mem_arbiter.sv
// Shares the single Veldt RAM port between instruction fetch (I) and load/store (D).
// Optional perf counters are enabled with `VELDT_ARB_PERF_EN.
module veldt_mem_arbiter
    import veldt_mem_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic clock,
    input  logic reset,
    veldt_mem_arbiter_if.slave bus
`ifdef VELDT_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
`endif
);

    logic                gnt_i, gnt_d;
    logic [ADDR_W-1:0]   i_addr, d_addr;
    logic [RAM_IN_W-1:0] ram_in_d, ram_in_q;
    tag_t                tag_in, head;
    tag_t                tag_pipe [RAM_LAT:0];

    veldt_rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .req_i (bus.i_req_valid),
        .req_d (bus.d_req_valid),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    assign bus.i_req_ready = gnt_i;
    assign bus.d_req_ready = gnt_d;
    assign i_addr          = bus.i_req_addr;
    assign d_addr          = bus.d_req_addr;

    // Fetches never write, so their data/mask/we fields stay zero.
    always_comb begin
        ram_in_d = '0;
        if (gnt_i)
            ram_in_d = pack_req(32'(i_addr), 32'h0, 4'h0, 1'b0);
        else if (gnt_d)
            ram_in_d = pack_req(32'(d_addr), bus.d_req_wdata, bus.d_req_mask, bus.d_req_we);
    end

    always_comb begin
        tag_in = '{vld: gnt_i | gnt_d, owner: gnt_d ? OWN_D : OWN_I, we: gnt_d & bus.d_req_we};
    end

    // Stage 0 holds the tag during the issue cycle; stage RAM_LAT lines up with ram_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_in_q <= '0;
            for (int k = 0; k <= RAM_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            ram_in_q    <= ram_in_d;
            tag_pipe[0] <= tag_in;
            for (int k = 1; k <= RAM_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign bus.ram_in = ram_in_q;
    assign head       = tag_pipe[RAM_LAT];

    assign bus.i_rsp_valid = head.vld && (head.owner == OWN_I);
    assign bus.i_rsp_rdata = bus.i_rsp_valid ? bus.ram_out : 32'h0;
    assign bus.d_rsp_valid = head.vld && (head.owner == OWN_D);
    assign bus.d_rsp_rdata = (bus.d_rsp_valid && !head.we) ? bus.ram_out : 32'h0;

`ifdef VELDT_ARB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (gnt_i) perf_i_grants <= perf_i_grants + 32'd1;
            if (gnt_d) perf_d_grants <= perf_d_grants + 32'd1;
            if (bus.i_req_valid && bus.d_req_valid) perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_veldt_mem_arbiter.sv
// Bench for veldt_mem_arbiter: RAM_LAT=1 and RAM_LAT=3 instances share one stimulus
// stream and are checked against a cycle-scheduled reference model.
module tb_veldt_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv = 1'b0, dv = 1'b0, dwe = 1'b0;
    logic [31:0] ia = '0, da = '0, dwd = '0;
    logic [3:0]  dm = '0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    veldt_mem_arbiter_if #(.ADDR_W(32)) b1 ();
    veldt_mem_arbiter_if #(.ADDR_W(32)) b3 ();

    assign b1.i_req_valid = iv;  assign b3.i_req_valid = iv;
    assign b1.i_req_addr  = ia;  assign b3.i_req_addr  = ia;
    assign b1.d_req_valid = dv;  assign b3.d_req_valid = dv;
    assign b1.d_req_addr  = da;  assign b3.d_req_addr  = da;
    assign b1.d_req_we    = dwe; assign b3.d_req_we    = dwe;
    assign b1.d_req_wdata = dwd; assign b3.d_req_wdata = dwd;
    assign b1.d_req_mask  = dm;  assign b3.d_req_mask  = dm;

`ifdef VELDT_ARB_PERF_EN
    logic [31:0] p1_i, p1_d, p1_c, p3_i, p3_d, p3_c;
`endif

    veldt_mem_arbiter #(.RAM_LAT(1), .ADDR_W(32)) dut1 (.clock(clk), .reset(rst), .bus(b1)
`ifdef VELDT_ARB_PERF_EN
        , .perf_i_grants(p1_i), .perf_d_grants(p1_d), .perf_conflicts(p1_c)
`endif
    );
    veldt_mem_arbiter #(.RAM_LAT(3), .ADDR_W(32)) dut3 (.clock(clk), .reset(rst), .bus(b3)
`ifdef VELDT_ARB_PERF_EN
        , .perf_i_grants(p3_i), .perf_d_grants(p3_d), .perf_conflicts(p3_c)
`endif
    );

    // RAM contents as a fixed function of address; 0x100 holds 0xDEADBEEF.
    function automatic logic [31:0] f(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h0F0F1234);
    endfunction

    // RAM environment: read data appears RAM_LAT cycles after the request, junk otherwise.
    logic [96:0] h1 [0:3] = '{default: '0};
    logic [96:0] h3 [0:3] = '{default: '0};
    logic [31:0] junk = 32'h5555AAAA;
    always @(posedge clk) begin
        junk  <= $urandom;
        h1[0] <= b1.ram_in;
        h3[0] <= b3.ram_in;
        for (int k = 1; k < 4; k++) begin
            h1[k] <= h1[k-1];
            h3[k] <= h3[k-1];
        end
    end
    assign b1.ram_out = (h1[0][27] && !h1[0][28]) ? f(h1[0][96:65]) : junk;
    assign b3.ram_out = (h3[2][27] && !h3[2][28]) ? f(h3[2][96:65]) : junk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        i_rdy;
        logic        d_rdy;
        logic        i_rv;
        logic [31:0] i_rd;
        logic        d_rv;
        logic [31:0] d_rd;
        logic [96:0] ram_in;
    } obs_t;

    typedef struct packed {
        logic        v;
        logic        d;
        logic        we;
        logic [31:0] a;
    } sch_t;

    obs_t        obs [2];
    obs_t        ex  [2];
    sch_t        sched [2][8];
    logic        m_last_d = 1'b0, m_gi = 1'b0, m_gd = 1'b0;
    logic [96:0] m_ram = '0;
    int          cyc = 0;

    function automatic int lat(input int j);
        return (j == 0) ? 1 : 3;
    endfunction

    // Read data is only meaningful while its rsp_valid is expected.
    function automatic obs_t masked(input obs_t o, input obs_t e);
        obs_t r;
        r = o;
        if (!e.i_rv) r.i_rd = '0;
        if (!e.d_rv) r.d_rd = '0;
        return r;
    endfunction

    task automatic model_reset();
        m_last_d = 1'b0;
        m_ram    = '0;
        for (int j = 0; j < 2; j++)
            for (int s = 0; s < 8; s++) sched[j][s] = '0;
    endtask

    task automatic model_eval();
        sch_t s;
        if (iv && dv) begin
            m_gd = !m_last_d;
            m_gi = m_last_d;
        end else begin
            m_gi = iv;
            m_gd = dv;
        end
        for (int j = 0; j < 2; j++) begin
            s = sched[j][cyc % 8];
            ex[j] = {m_gi, m_gd,
                     s.v && !s.d, (s.v && !s.d) ? f(s.a) : 32'h0,
                     s.v && s.d,  (s.v && s.d && !s.we) ? f(s.a) : 32'h0,
                     m_ram};
        end
    endtask

    task automatic model_commit();
        if (m_gi || m_gd) m_last_d = m_gd;
        if (m_gi)      m_ram = {ia, 32'h0, 4'h0, 1'b0, 1'b1, 27'h0};
        else if (m_gd) m_ram = {da, dwd, dm, dwe, 1'b1, 27'h0};
        else           m_ram = '0;
        for (int j = 0; j < 2; j++) begin
            sched[j][cyc % 8] = '0;
            if (m_gi || m_gd)
                sched[j][(cyc + 1 + lat(j)) % 8] = {1'b1, m_gd, m_gd && dwe, m_gi ? ia : da};
        end
        cyc++;
    endtask

    task automatic sample();
        obs[0] = {b1.i_req_ready, b1.d_req_ready, b1.i_rsp_valid, b1.i_rsp_rdata,
                  b1.d_rsp_valid, b1.d_rsp_rdata, b1.ram_in};
        obs[1] = {b3.i_req_ready, b3.d_req_ready, b3.i_rsp_valid, b3.i_rsp_rdata,
                  b3.d_rsp_valid, b3.d_rsp_rdata, b3.ram_in};
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic settle();
        #1;
        model_eval();
        sample();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        iv = 1'b0; dv = 1'b0; dwe = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        iv = 1'b1; dv = 1'b1; ia = 32'h40; da = 32'h80;
        for (int n = 0; n < 2; n++) begin
            #1;
            sample();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (obs[j] !== '0) begin
                    n_err++;
                    $display("FAIL reset_outputs dut%0d pass%0d: got %h want 0", j, n, obs[j]);
                end
            end
            @(negedge clk);
        end
        iv = 1'b0; dv = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_i();
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            iv = (k == 0); ia = 32'h100;
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL single_i_model dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
                n_cmp++;
                if (obs[j].d_rv !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_i_no_d_rsp dut%0d k%0d: got %b want 0", j, k, obs[j].d_rv);
                end
            end
            if (k == 0) begin
                n_cmp++;
                if (obs[0].i_rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_i_ready: got %b want 1", obs[0].i_rdy);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (obs[0].ram_in[96:65] !== 32'h100 || obs[0].ram_in[27] !== 1'b1) begin
                    n_err++;
                    $display("FAIL single_i_ram_in: got addr %h req %b want 100/1", obs[0].ram_in[96:65], obs[0].ram_in[27]);
                end
            end
            n_cmp++;
            if (obs[0].i_rv !== (k == 2) || (k == 2 && obs[0].i_rd !== 32'hDEADBEEF)) begin
                n_err++;
                $display("FAIL single_i_rsp k%0d: got v%b %h want v%b DEADBEEF", k, obs[0].i_rv, obs[0].i_rd, k == 2);
            end
            advance();
        end
    endtask

    task automatic test_alternate();
        int ni, nd;
        ni = 0; nd = 0;
        apply_reset();
        iv = 1'b1; dv = 1'b1; ia = 32'h1000; da = 32'h2000; dwe = 1'b0; dm = 4'h0; dwd = '0;
        for (int k = 0; k < 20; k++) begin
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL alt_model dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            n_cmp++;
            if (obs[0].d_rdy !== (k % 2 == 0) || obs[0].i_rdy !== (k % 2 == 1)) begin
                n_err++;
                $display("FAIL alt_order k%0d: got i%b d%b want i%b d%b", k, obs[0].i_rdy, obs[0].d_rdy, k % 2 == 1, k % 2 == 0);
            end
            ni += int'(obs[0].i_rdy);
            nd += int'(obs[0].d_rdy);
            advance();
            if (m_last_d) begin da = $urandom & ~32'h3; dwe = $urandom_range(0, 1); dwd = $urandom; dm = 4'($urandom); end
            else ia = $urandom & ~32'h3;
        end
        n_cmp++;
        if (ni !== 10 || nd !== 10) begin
            n_err++;
            $display("FAIL alt_share: got i%0d d%0d want 10/10", ni, nd);
        end
        iv = 1'b0; dv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL alt_drain dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            advance();
        end
    endtask

    task automatic test_store();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            dv  = (k < 2); dwe = 1'b1;
            da  = (k == 0) ? 32'h20 : 32'h24;
            dwd = (k == 0) ? 32'h12345678 : 32'hCAFEF00D;
            dm  = (k == 0) ? 4'hF : 4'h0;
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL store_model dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            if (k == 1) begin
                n_cmp++;
                if (obs[0].ram_in[28] !== 1'b1 || obs[0].ram_in[32:29] !== 4'hF || obs[0].ram_in[64:33] !== 32'h12345678
                    || obs[0].ram_in[96:65] !== 32'h20) begin
                    n_err++;
                    $display("FAIL store_ram_in: got %h want we1 maskF data 12345678 addr 20", obs[0].ram_in);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (obs[0].ram_in[27] !== 1'b1 || obs[0].ram_in[32:29] !== 4'h0) begin
                    n_err++;
                    $display("FAIL store_mask0_issue: got req %b mask %h want 1/0", obs[0].ram_in[27], obs[0].ram_in[32:29]);
                end
            end
            n_cmp++;
            if (obs[0].d_rv !== (k == 2 || k == 3) || obs[0].d_rd !== 32'h0) begin
                n_err++;
                $display("FAIL store_ack k%0d: got v%b %h want v%b 0", k, obs[0].d_rv, obs[0].d_rd, k == 2 || k == 3);
            end
            advance();
        end
    endtask

    task automatic test_lat3_b2b();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            iv = (k < 3);
            ia = (k < 3) ? addrs[k] : 32'h0;
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL b2b_model dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            n_cmp++;
            if (obs[1].i_rv !== (k >= 4 && k <= 6) || (k >= 4 && k <= 6 && obs[1].i_rd !== f(addrs[k-4]))) begin
                n_err++;
                $display("FAIL b2b_lat3_rsp k%0d: got v%b %h want v%b", k, obs[1].i_rv, obs[1].i_rd, k >= 4 && k <= 6);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            iv = 1'b1; ia = 32'h300 + 32'(k * 4);
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL rmid_pre dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            advance();
        end
        iv = 1'b1; dv = 1'b1; da = 32'h500;
        #2;
        rst = 1'b1;
        #1;
        sample();
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (obs[j] !== '0) begin
                n_err++;
                $display("FAIL rmid_async dut%0d: got %h want 0", j, obs[j]);
            end
        end
        @(negedge clk);
        iv = 1'b0; dv = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (obs[j].i_rv !== 1'b0 || obs[j].d_rv !== 1'b0 || obs[j].ram_in !== '0) begin
                    n_err++;
                    $display("FAIL rmid_after dut%0d k%0d: got %h want 0", j, k, obs[j]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic ip, dp;
        ip = 1'b0; dp = 1'b0;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            if (!ip) begin
                iv = ($urandom_range(0, 2) != 0);
                ia = $urandom & ~32'h3;
            end
            if (!dp) begin
                dv  = ($urandom_range(0, 2) != 0);
                da  = (k % 11 == 0) ? 32'h100 : ($urandom & ~32'h3);
                dwe = $urandom_range(0, 1);
                dwd = $urandom;
                dm  = 4'($urandom);
            end
            settle();
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (masked(obs[j], ex[j]) !== ex[j]) begin
                    n_err++;
                    $display("FAIL random dut%0d k%0d: got %h want %h", j, k, masked(obs[j], ex[j]), ex[j]);
                end
            end
            ip = iv && !m_gi;
            dp = dv && !m_gd;
            advance();
        end
    endtask

`ifdef VELDT_ARB_PERF_EN
    task automatic test_perf();
        apply_reset();
        iv = 1'b1; dv = 1'b1; ia = 32'h10; da = 32'h14; dwe = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            advance();
        end
        iv = 1'b0; dv = 1'b0;
        settle();
        n_cmp++;
        if (p1_c !== 32'd10 || p1_i !== 32'd5 || p1_d !== 32'd5) begin
            n_err++;
            $display("FAIL perf_dut1: got c%0d i%0d d%0d want 10/5/5", p1_c, p1_i, p1_d);
        end
        n_cmp++;
        if (p3_c !== 32'd10 || p3_i !== 32'd5 || p3_d !== 32'd5) begin
            n_err++;
            $display("FAIL perf_dut3: got c%0d i%0d d%0d want 10/5/5", p3_c, p3_i, p3_d);
        end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_single_i();
        test_alternate();
        test_store();
        test_lat3_b2b();
        test_reset_mid();
        test_random();
`ifdef VELDT_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/veldt_mem_arbiter.md
Name: veldt_mem_arbiter

Overview:
- Shares the single Veldt RAM port (97-bit request bus `ram_in`, 32-bit read bus `ram_out`) between two requesters.
- Requester I is instruction fetch; requester D is load/store.
- Issues at most one RAM request per cycle and routes each fixed-latency response back to its originator via a tag pipeline.
- Sits between the core front-end/LSU and the RAM model in both the synthesis top and the formal wrapper.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles from request issue to valid `ram_out` (legal 1..4).
- ADDR_W, 32, address width.

Ports:
- clock in 1 system clock
- reset in 1 asynchronous, active-high reset
- i_req_valid in 1 fetch request valid
- i_req_ready out 1 fetch request accepted this cycle
- i_req_addr in ADDR_W fetch word address
- i_rsp_valid out 1 fetch response valid (single-cycle pulse)
- i_rsp_rdata out 32 fetch read data
- d_req_valid in 1 data request valid
- d_req_ready out 1 data request accepted this cycle
- d_req_addr in ADDR_W data address
- d_req_we in 1 1 = store, 0 = load
- d_req_wdata in 32 store data
- d_req_mask in 4 store byte enables
- d_rsp_valid out 1 data response valid (single-cycle pulse)
- d_rsp_rdata out 32 load data (0 for store acks)
- ram_in out 97 packed RAM request
- ram_out in 32 RAM read data

Behaviour:
- Reset values (asserted asynchronously): all outputs 0, tag pipeline empty, last-grant pointer = I.
- **ram_in packing:**
  - [96:65] addr
  - [64:33] wdata
  - [32:29] mask
  - [28] we
  - [27] req
  - [26:0] 0
- ram_in fields when idle: all zero.
- ram_in fields for an I grant: we = 0, mask = 0, wdata = 0.
- **Arbitration:** combinational, same cycle.
  - Only one requester valid: it is granted.
  - Both valid: round-robin; grant goes to the side not granted last.
  - Pointer updates only on an actual grant.
- Requests are registered. A request granted in cycle t drives ram_in with req = 1 in cycle t+1.
- `x_req_ready` = grant. A requester must hold valid, addr and data stable until ready is seen.
- **Tag pipeline:** RAM_LAT+1 stages of {valid, owner, we}. The entry enters stage 0 on issue.
- **Response:** in cycle t+1+RAM_LAT, the owner's rsp_valid pulses for one cycle.
  - rdata = ram_out for reads.
  - rdata = 0 for store acks.
  - The other side's rsp_valid stays 0.
- Responses cannot be back-pressured. Throughput is one request per cycle. Ordering within each requester is preserved.
- A D store with mask = 0 is still issued and acked, since the RAM treats it as a no-op.
- **Reset mid-operation:** in-flight tags are discarded and no responses appear after reset deasserts. Requesters must reissue.
- Simultaneous response and new grant in the same cycle is legal; both paths are independent.

Optional Feature:
- Macro: `VELDT_ARB_PERF_EN`.
- When defined, adds outputs:
  - perf_i_grants (32)
  - perf_d_grants (32)
  - perf_conflicts (32), counting cycles with both valid.
- Counters wrap at 2^32 and reset to 0.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `veldt_mem_pkg` holds:
  - the ram_in field offset constants (ADDR_LSB = 65, WDATA_LSB = 33, MASK_LSB = 29, WE_BIT = 28, REQ_BIT = 27)
  - the owner enum {OWN_I, OWN_D}
  - a packed struct for the tag entry
- One natural sub-module: `veldt_rr_arb2`, a two-way round-robin grant plus pointer register.

Test Plan:
- Only I valid, addr 0x100, RAM_LAT = 1, ram_out = 0xDEADBEEF → i_req_ready same cycle; ram_in[96:65] = 0x100 with req = 1 next cycle; i_rsp_valid with 0xDEADBEEF two cycles after grant; d_rsp_valid never set.
- I and D both valid continuously after reset → D granted first, then alternating I, D, I…; each side gets exactly 50% of grants over 20 cycles.
- D store addr 0x20, wdata 0x12345678, mask 0xF → ram_in we = 1, mask = 0xF, wdata = 0x12345678; d_rsp_valid pulse with rdata 0.
- RAM_LAT = 3, I issues back-to-back 0x0, 0x4, 0x8 → three responses on consecutive cycles in order, starting 4 cycles after the first grant.
- Reset asserted while 2 reads are in flight → all outputs drop to 0 asynchronously; no rsp_valid after release; ram_in = 0.
- `VELDT_ARB_PERF_EN` defined, 10 cycles with both valid → perf_conflicts = 10, perf_i_grants = 5, perf_d_grants = 5.
